tpu_job_scheduler: RTL and testbench
====================================

# tpu_job_scheduler

Front-end scheduler for the systolic TPU core. It arbitrates job requests from NUM_REQ requesters round-robin and issues a one-cycle `tpu_start` pulse to the core for the granted job. It then waits for `tpu_done`, applying a watchdog timeout and an abort, and returns a tagged completion to the originating requester. It sits between host-side command sources and the `tpu_start`/`tpu_done` pins of the TPU top level.

## Interface
Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- ID_WIDTH, 4, job tag width
- TIMEOUT_CYCLES, 1000, max RUN cycles before timeout error (1..65535)

Ports:
- clk  input  1  clock; all logic is rising-edge
- srstn  input  1  asynchronous, active-low reset
- req_valid  input  NUM_REQ  per-requester job request
- req_id  input  NUM_REQ*ID_WIDTH  per-requester job tag; requester i uses bits [i*ID_WIDTH +: ID_WIDTH]
- req_ready  output  NUM_REQ  one-hot accept; at most one bit high
- tpu_start  output  1  one-cycle start pulse to the TPU core
- tpu_done  input  1  completion pulse from the TPU core
- abort  input  1  cancels the running job
- done_valid  output  1  completion available
- done_ready  input  1  completion consumed
- done_grant  output  NUM_REQ  one-hot owner of the completion
- done_id  output  ID_WIDTH  tag of the completed job
- done_err  output  1  1 = timeout or abort, 0 = normal done
- busy  output  1  high whenever the state is not IDLE
- jobs_done  output  16  count of error-free completions; wraps at 65535 -> 0

## Operation
- FSM states: IDLE, START, RUN, REPORT.
- IDLE:
  - If any req_valid is high, the grant is the first valid requester searching from (last_grant+1) mod NUM_REQ upward.
  - req_ready[grant] is combinationally high in this cycle.
  - At the edge, capture req_id[grant] and the grant, then go to START.
- START: tpu_start=1 for exactly this cycle; timer cleared to 0; next state RUN.
- RUN: timer increments each cycle. Exit conditions in priority order:
  - tpu_done=1 -> REPORT with err=0.
  - Otherwise abort=1 -> REPORT with err=1.
  - Otherwise timer==TIMEOUT_CYCLES-1 -> REPORT with err=1.
- REPORT:
  - done_valid=1; done_grant, done_id and done_err are held stable.
  - On done_valid&done_ready: last_grant <= grant; jobs_done increments if err=0; go to IDLE.
- tpu_done outside RUN is ignored. abort outside RUN is ignored.
- The round-robin pointer advances only on completion, so a timed-out requester still loses priority to the next requester.
- Requesters must hold req_valid and req_id until req_ready. Deassertion before grant is legal and withdraws the request.

## Timing
- Reset (async assert) drives the FSM to IDLE and sets:
  - tpu_start=0, done_valid=0, done_grant=0, done_id=0, done_err=0, busy=0, jobs_done=0, timer=0.
  - last_grant=NUM_REQ-1, so requester 0 wins first.
- Reset mid-job drops tpu_start and done_valid immediately without waiting for a clock edge. The job is lost and no completion is reported.
- Accept at edge k; tpu_start high during cycle k+1; busy high from cycle k+1.
- tpu_done sampled high at edge m gives done_valid high from cycle m+1.
- Minimum throughput: IDLE -> START -> RUN (≥1 cycle) -> REPORT (≥1 cycle) = 4 cycles per job.
- Timeout: with no tpu_done, done_valid rises exactly TIMEOUT_CYCLES+1 cycles after the tpu_start cycle.
- tpu_done and timeout in the same cycle: tpu_done wins (err=0).
- tpu_done and abort in the same cycle: tpu_done wins.
- done_ready high while done_valid=0 has no effect.
- done_valid stays high indefinitely under backpressure. No new grant is made until the completion is consumed.
- All outputs are registered except req_ready.

## Test plan
- Reset, then req_valid=4'b0001 with id 3; tpu_done 5 cycles after tpu_start -> exactly one tpu_start pulse; done_valid with done_grant=0001, done_id=3, done_err=0; jobs_done=1.
- All four requesters continuously valid, 8 jobs -> grant order 0,1,2,3,0,1,2,3; never two req_ready bits high; tpu_start count = 8.
- TIMEOUT_CYCLES=10, tpu_done never asserted -> done_valid exactly 11 cycles after tpu_start, done_err=1, jobs_done unchanged; next requester granted afterward.
- tpu_done and timeout in the same cycle -> done_err=0. abort in RUN -> done_err=1 on the next cycle. tpu_done pulse in IDLE -> no state change.
- done_ready held low 20 cycles with other requests pending -> done_valid and its fields stable, no req_ready, no tpu_start; release -> next grant the following cycle.
- srstn asserted during RUN and during REPORT -> all outputs 0 asynchronously; after release, requester 0 has priority; 65536 successful jobs wrap jobs_done to 0.

Source files
------------

// File: rtl/tpu_job_scheduler.sv
// Front-end job scheduler for the systolic TPU core: round-robin request arbitration,
// start pulse generation, done/abort/timeout supervision and tagged completion return.
module tpu_job_scheduler #(
  parameter int NUM_REQ        = 4,
  parameter int ID_WIDTH       = 4,
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic                        clk,
  input  logic                        srstn,
  input  logic [NUM_REQ-1:0]          req_valid,
  input  logic [NUM_REQ*ID_WIDTH-1:0] req_id,
  output logic [NUM_REQ-1:0]          req_ready,
  output logic                        tpu_start,
  input  logic                        tpu_done,
  input  logic                        abort,
  output logic                        done_valid,
  input  logic                        done_ready,
  output logic [NUM_REQ-1:0]          done_grant,
  output logic [ID_WIDTH-1:0]         done_id,
  output logic                        done_err,
  output logic                        busy,
  output logic [15:0]                 jobs_done
);

  localparam int          GW   = $clog2(NUM_REQ);
  localparam logic [15:0] TMAX = 16'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, START, RUN, REPORT} state_e;

  state_e              state_q, state_d;
  logic [GW-1:0]       last_grant_q, last_grant_d;
  logic [GW-1:0]       grant_q, grant_d;
  logic [ID_WIDTH-1:0] id_q, id_d;
  logic [15:0]         timer_q, timer_d;
  logic [15:0]         jobs_q, jobs_d;
  logic                run_err;

  logic                tpu_start_q, done_valid_q, busy_q, done_err_q;
  logic [NUM_REQ-1:0]  done_grant_q;
  logic [ID_WIDTH-1:0] done_id_q;

  logic [GW-1:0]       cand, arb_idx;
  logic                arb_found;
  logic [ID_WIDTH-1:0] sel_id;
  logic [NUM_REQ-1:0]  grant_oh;

  // Round-robin search starting one past the requester that last completed.
  always_comb begin
    arb_found = 1'b0;
    arb_idx   = '0;
    cand      = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand = GW'((int'(last_grant_q) + i) % NUM_REQ);
      if (!arb_found && req_valid[cand]) begin
        arb_found = 1'b1;
        arb_idx   = cand;
      end
    end
    sel_id = '0;
    for (int j = 0; j < NUM_REQ; j++) begin
      if (arb_idx == GW'(j)) sel_id = req_id[j*ID_WIDTH +: ID_WIDTH];
    end
    req_ready = '0;
    if (state_q == IDLE && arb_found) req_ready[arb_idx] = 1'b1;
    grant_oh = '0;
    grant_oh[grant_q] = 1'b1;
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    grant_d      = grant_q;
    id_d         = id_q;
    timer_d      = timer_q;
    jobs_d       = jobs_q;
    run_err      = 1'b0;
    case (state_q)
      IDLE: begin
        if (arb_found) begin
          grant_d = arb_idx;
          id_d    = sel_id;
          state_d = START;
        end
      end
      START: begin
        timer_d = '0;
        state_d = RUN;
      end
      RUN: begin
        timer_d = timer_q + 16'd1;
        // A same-cycle done beats both abort and timeout.
        if (tpu_done) begin
          state_d = REPORT;
        end else if (abort || timer_q == TMAX) begin
          run_err = 1'b1;
          state_d = REPORT;
        end
      end
      REPORT: begin
        if (done_ready) begin
          last_grant_d = grant_q;
          if (!done_err_q) jobs_d = jobs_q + 16'd1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge srstn) begin
    if (!srstn) begin
      state_q      <= IDLE;
      last_grant_q <= GW'(NUM_REQ - 1);
      grant_q      <= '0;
      id_q         <= '0;
      timer_q      <= '0;
      jobs_q       <= '0;
      tpu_start_q  <= 1'b0;
      done_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      done_grant_q <= '0;
      done_id_q    <= '0;
      done_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      grant_q      <= grant_d;
      id_q         <= id_d;
      timer_q      <= timer_d;
      jobs_q       <= jobs_d;
      tpu_start_q  <= (state_d == START);
      done_valid_q <= (state_d == REPORT);
      busy_q       <= (state_d != IDLE);
      // Completion fields are frozen on REPORT entry and cleared once consumed.
      if (state_q == RUN && state_d == REPORT) begin
        done_grant_q <= grant_oh;
        done_id_q    <= id_q;
        done_err_q   <= run_err;
      end else if (state_d != REPORT) begin
        done_grant_q <= '0;
        done_id_q    <= '0;
        done_err_q   <= 1'b0;
      end
    end
  end

  assign tpu_start  = tpu_start_q;
  assign done_valid = done_valid_q;
  assign busy       = busy_q;
  assign done_grant = done_grant_q;
  assign done_id    = done_id_q;
  assign done_err   = done_err_q;
  assign jobs_done  = jobs_q;

endmodule

// File: tb/tb_tpu_job_scheduler.sv
// Bench for tpu_job_scheduler: job-level reference model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_tpu_job_scheduler;
  localparam int NR = 4;
  localparam int IW = 4;
  localparam int T  = 10;

  logic              clk = 1'b0;
  logic              srstn = 1'b0;
  logic [NR-1:0]     req_valid = '0;
  logic [NR*IW-1:0]  req_id = '0;
  logic [NR-1:0]     req_ready;
  logic              tpu_start;
  logic              tpu_done = 1'b0;
  logic              abort = 1'b0;
  logic              done_valid;
  logic              done_ready = 1'b0;
  logic [NR-1:0]     done_grant;
  logic [IW-1:0]     done_id;
  logic              done_err;
  logic              busy;
  logic [15:0]       jobs_done;

  int checks = 0;
  int failures = 0;
  int n_start = 0;
  logic cmp_en = 1'b0;

  tpu_job_scheduler #(.NUM_REQ(NR), .ID_WIDTH(IW), .TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .srstn(srstn), .req_valid(req_valid), .req_id(req_id),
    .req_ready(req_ready), .tpu_start(tpu_start), .tpu_done(tpu_done),
    .abort(abort), .done_valid(done_valid), .done_ready(done_ready),
    .done_grant(done_grant), .done_id(done_id), .done_err(done_err),
    .busy(busy), .jobs_done(jobs_done)
  );

  always #5 clk = ~clk;

  // Job-level reference: one job record, phases measured in cycles since its start pulse.
  int          cyc = 0;
  int          m_start = 0;
  int          m_lastg = NR - 1;
  int          m_owner = 0;
  logic        m_active = 1'b0;
  logic        m_fin = 1'b0;
  logic        m_err = 1'b0;
  logic        acc_now = 1'b0;
  logic [IW-1:0] m_id = '0;
  logic [15:0] m_jobs = '0;

  function automatic int arb(input logic [NR-1:0] v, input int lastg);
    for (int i = 1; i <= NR; i++) begin
      if (v[(lastg + i) % NR]) return (lastg + i) % NR;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_active = 1'b0; m_fin = 1'b0; m_err = 1'b0; acc_now = 1'b0;
    m_lastg = NR - 1; m_jobs = '0;
  endtask

  initial begin
    int j, g;
    model_reset();
    forever begin
      @(posedge clk or negedge srstn);
      if (!srstn) begin
        model_reset();
      end else begin
        acc_now = 1'b0;
        if (m_active && m_fin) begin
          if (done_ready) begin
            m_lastg = m_owner;
            if (!m_err) m_jobs = m_jobs + 16'd1;
            m_active = 1'b0;
            m_fin = 1'b0;
          end
        end else if (m_active) begin
          j = cyc - m_start;
          if (j >= 1) begin
            if (tpu_done) begin m_fin = 1'b1; m_err = 1'b0; end
            else if (abort) begin m_fin = 1'b1; m_err = 1'b1; end
            else if (j == T) begin m_fin = 1'b1; m_err = 1'b1; end
          end
        end else begin
          g = arb(req_valid, m_lastg);
          if (g >= 0) begin
            m_active = 1'b1;
            m_owner = g;
            m_id = req_id[g*IW +: IW];
            m_start = cyc + 1;
            acc_now = 1'b1;
          end
        end
        cyc++;
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  initial forever begin
    @(negedge clk);
    if (srstn && tpu_start) n_start++;
  end

  // Per-cycle comparison against the model.
  initial forever begin
    logic [NR-1:0] er;
    int g;
    @(negedge clk);
    if (srstn && cmp_en) begin
      er = '0;
      g = arb(req_valid, m_lastg);
      if (!m_active && g >= 0) er = NR'(32'd1 << g);
      chk("cmp_req_ready", req_ready, er);
      chk("cmp_tpu_start", tpu_start, m_active && (cyc == m_start));
      chk("cmp_busy", busy, m_active);
      chk("cmp_done_valid", done_valid, m_fin);
      chk("cmp_jobs_done", jobs_done, m_jobs);
      if (m_fin) begin
        chk("cmp_done_grant", done_grant, 32'd1 << m_owner);
        chk("cmp_done_id", done_id, m_id);
        chk("cmp_done_err", done_err, m_err);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    srstn = 1'b0; req_valid = '0; tpu_done = 1'b0; abort = 1'b0; done_ready = 1'b0;
    repeat (2) @(posedge clk);
    #2 srstn = 1'b1;
  endtask

  task automatic wait_ready(output int g);
    g = -1;
    for (int k = 0; k < 20 && g < 0; k++) begin
      #1;
      for (int i = 0; i < NR; i++) if (req_ready[i]) g = i;
      if (g < 0) step();
    end
    if (g < 0) chk("wait_ready_timeout", 0, 1);
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (!done_valid && n < 40) begin step(); n++; end
    if (!done_valid) chk("wait_done_timeout", 0, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int g, n, n0;
    // Reset state and a single job from requester 0.
    do_reset();
    cmp_en = 1'b1;
    chk("rst_tpu_start", tpu_start, 0);
    chk("rst_done_valid", done_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_jobs_done", jobs_done, 0);
    chk("rst_done_grant", done_grant, 0);
    chk("rst_done_id", done_id, 0);
    chk("rst_done_err", done_err, 0);
    n0 = n_start;
    req_valid = 4'b0001; req_id[3:0] = 4'd3;
    #1 chk("t1_req_ready", req_ready, 4'b0001);
    step();
    req_valid = '0;
    chk("t1_tpu_start", tpu_start, 1);
    chk("t1_busy", busy, 1);
    repeat (5) step();
    tpu_done = 1'b1; step(); tpu_done = 1'b0;
    chk("t1_done_valid", done_valid, 1);
    chk("t1_done_grant", done_grant, 4'b0001);
    chk("t1_done_id", done_id, 3);
    chk("t1_done_err", done_err, 0);
    done_ready = 1'b1; step(); done_ready = 1'b0;
    chk("t1_jobs_done", jobs_done, 1);
    chk("t1_idle", busy, 0);
    chk("t1_start_count", n_start - n0, 1);

    // Round robin with all requesters valid.
    do_reset();
    req_valid = 4'b1111;
    for (int i = 0; i < NR; i++) req_id[i*IW +: IW] = IW'(i + 1);
    done_ready = 1'b1;
    n0 = n_start;
    for (int k = 0; k < 8; k++) begin
      wait_ready(g);
      chk("rr_order", g, k % NR);
      step(); step();
      tpu_done = 1'b1; step(); tpu_done = 1'b0;
      chk("rr_done_id", done_id, g + 1);
      step();
    end
    chk("rr_start_count", n_start - n0, 8);
    chk("rr_jobs_done", jobs_done, 8);

    // Timeout: requester 0 next, done_valid T+1 cycles after the start pulse.
    done_ready = 1'b0;
    wait_ready(g);
    chk("to_grant", g, 0);
    step();
    chk("to_tpu_start", tpu_start, 1);
    wait_done(n);
    chk("to_latency", n, T + 1);
    chk("to_done_err", done_err, 1);
    chk("to_jobs_done", jobs_done, 8);
    done_ready = 1'b1; step(); done_ready = 1'b0;
    #1 chk("to_next_grant", req_ready, 4'b0010);

    // tpu_done on the timeout cycle wins.
    step();
    repeat (T) step();
    tpu_done = 1'b1; step(); tpu_done = 1'b0;
    chk("tie_done_valid", done_valid, 1);
    chk("tie_done_err", done_err, 0);
    chk("tie_done_grant", done_grant, 4'b0010);
    done_ready = 1'b1; step(); done_ready = 1'b0;
    chk("tie_jobs_done", jobs_done, 9);

    // Abort in RUN.
    wait_ready(g);
    chk("ab_grant", g, 2);
    step(); step(); step();
    abort = 1'b1; step(); abort = 1'b0;
    chk("ab_done_valid", done_valid, 1);
    chk("ab_done_err", done_err, 1);
    done_ready = 1'b1; step(); done_ready = 1'b0;
    chk("ab_jobs_done", jobs_done, 9);

    // tpu_done/abort while idle are ignored.
    req_valid = '0;
    step();
    tpu_done = 1'b1; abort = 1'b1; step(); tpu_done = 1'b0; abort = 1'b0;
    step();
    chk("idle_busy", busy, 0);
    chk("idle_done_valid", done_valid, 0);
    chk("idle_jobs_done", jobs_done, 9);

    // Backpressure on the completion with other requests pending.
    req_valid = 4'b1111;
    wait_ready(g);
    chk("bp_grant", g, 3);
    step(); step();
    tpu_done = 1'b1; step(); tpu_done = 1'b0;
    n0 = n_start;
    repeat (20) begin
      step();
      chk("bp_done_valid", done_valid, 1);
      chk("bp_done_grant", done_grant, 4'b1000);
      chk("bp_done_id", done_id, 4);
      #1 chk("bp_req_ready", req_ready, 0);
    end
    chk("bp_no_start", n_start - n0, 0);
    done_ready = 1'b1; step(); done_ready = 1'b0;
    #1 chk("bp_release_grant", req_ready, 4'b0001);

    // Complete a job for requester 0, then reset while requester 1 runs.
    step(); step();
    tpu_done = 1'b1; step(); tpu_done = 1'b0;
    done_ready = 1'b1; step(); done_ready = 1'b0;
    wait_ready(g);
    chk("rs_pre_grant", g, 1);
    step(); step();
    #1 srstn = 1'b0;
    #1;
    chk("rs_run_busy", busy, 0);
    chk("rs_run_tpu_start", tpu_start, 0);
    chk("rs_run_done_valid", done_valid, 0);
    chk("rs_run_jobs_done", jobs_done, 0);
    @(posedge clk); #2 srstn = 1'b1;
    #1 chk("rs_priority", req_ready, 4'b0001);

    // Reset while holding a completion.
    step(); step();
    tpu_done = 1'b1; step(); tpu_done = 1'b0;
    chk("rs_rep_valid_before", done_valid, 1);
    #1 srstn = 1'b0;
    #1;
    chk("rs_rep_done_valid", done_valid, 0);
    chk("rs_rep_done_grant", done_grant, 0);
    chk("rs_rep_done_id", done_id, 0);
    chk("rs_rep_busy", busy, 0);
    @(posedge clk); #2 srstn = 1'b1;

    // Randomized traffic against the model.
    req_valid = '0;
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < NR; i++) begin
        if (acc_now && m_owner == i) begin
          req_valid[i] = ($urandom % 3 == 0);
          req_id[i*IW +: IW] = IW'($urandom);
        end else if (req_valid[i]) begin
          if ($urandom % 20 == 0) req_valid[i] = 1'b0;
        end else if ($urandom % 4 == 0) begin
          req_valid[i] = 1'b1;
          req_id[i*IW +: IW] = IW'($urandom);
        end
      end
      tpu_done   = ($urandom % 8 == 0);
      abort      = ($urandom % 16 == 0);
      done_ready = ($urandom % 3 != 0);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
